pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RV32 pipeline (F/D/E/M/W). It replaces the purely combinational hazard unit. It adds:
- per-stage stall enables for all five stages;
- wait-state handshakes for instruction and data memory;
- a configurable multi-cycle load-use interlock;
- a data-memory wait watchdog.

It sits beside the datapath and drives every pipeline-register enable/clear and both forwarding muxes.

Parameters:
REG_AW, 5, register-address width (x0 = all zeros, never forwarded or interlocked).
LOAD_STALL, 1, load-use bubble cycles, legal 1..3.
MAX_WAIT, 15, data-memory wait cycles before timeout flag, legal 1..255.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
Rs1D, Rs2D  in  REG_AW  source regs in D
Rs1E, Rs2E, RdE  in  REG_AW  source/dest regs in E
RdM, RdW  in  REG_AW  dest regs in M, W
RegWriteM, RegWriteW  in  1  write-enable in M, W
LoadE  in  1  E holds a load
MemReqM  in  1  M holds a load or store
dmem_ready  in  1  data memory completes access this cycle
imem_ready  in  1  instruction word valid this cycle
PCSrcE  in  1  taken branch/jump resolved in E
ForwardAE, ForwardBE  out  2  00 regfile, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM, StallW  out  1  hold stage register
FlushD, FlushE  out  1  clear stage register to bubble
err_timeout  out  1  sticky watchdog flag
load_cnt  out  2  remaining load-use bubbles (debug)

Behaviour:
- Reset (reset=0, async):
  - state=RUN; counters 0; err_timeout=0.
  - All stalls 0, flushes 0, forwards 00.
- Forwarding (combinational):
  - Per operand: M match (RegWriteM, RdM!=0, RdM==RsXE) → 10.
  - Else W match → 01.
  - Else 00. M has priority over W.
- States:
  - RUN, LHOLD (load-use bubbles), DWAIT (data memory stall).
- Memory stall (mstall = MemReqM & ~dmem_ready):
  - Highest priority.
  - StallF/D/E/M/W=1; no flushes.
  - W holds, so the regfile rewrite is idempotent.
  - RUN/LHOLD → DWAIT on mstall. LHOLD is suspended: load_cnt is frozen and resumes after DWAIT.
  - DWAIT → previous state (RUN or LHOLD) in the cycle dmem_ready=1; stalls deassert that same cycle.
- Watchdog:
  - Counts DWAIT cycles and saturates.
  - On reaching MAX_WAIT, err_timeout=1 until reset.
  - Pipeline keeps waiting; counter clears on leaving DWAIT.
- Load-use (lu = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)), no mstall:
  - StallF=1, StallD=1, FlushE=1.
  - If LOAD_STALL>1: load_cnt=LOAD_STALL-1, RUN→LHOLD.
  - LHOLD: same StallF/StallD/FlushE; load_cnt decrements; →RUN when load_cnt==1 (last bubble).
- Branch redirect, no mstall:
  - PCSrcE → FlushD=1, FlushE=1.
  - Overrides load-use: the consumer is squashed, and LHOLD → RUN with load_cnt=0.
- Fetch wait (~imem_ready, no mstall, no lu, no LHOLD):
  - StallF=1, FlushD=1 (bubble into D); E/M/W advance.
  - PCSrcE during ~imem_ready: PC redirect still taken (StallF=0 that cycle), FlushD=1, FlushE=1.
- Simultaneous events, priority order:
  1. mstall
  2. PCSrcE
  3. load-use / LHOLD
  4. fetch wait
- Outputs are combinational from state and inputs.
- State/counter registers update on posedge clk only.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cyc[31:0] (cycles with StallD=1) and perf_flush_cnt[31:0] (cycles with FlushE=1).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports absent; no counter logic.

Decomposition:
- Package pipe_hazard_pkg:
  - state enum (RUN, LHOLD, DWAIT);
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, hazard_wdog: DWAIT cycle counter with saturate, compare to MAX_WAIT, and sticky flag.
- Forwarding compare stays inline.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. Same with RdM=0 → ForwardAE=01.
- LOAD_STALL=2, LoadE=1, RdE=7, Rs2D=7 → StallF/StallD/FlushE high exactly 2 cycles, load_cnt 1→0, then RUN.
- MemReqM=1, dmem_ready=0 for 4 cycles then 1 → all five stalls high 4 cycles, drop on the ready cycle, no flushes.
- MAX_WAIT=3, dmem_ready held 0 → err_timeout rises after 3rd DWAIT cycle and stays 1 after ready returns, until reset.
- PCSrcE=1 coincident with load-use and imem_ready=0 → FlushD=1, FlushE=1, StallF=0, state RUN.
- Assert reset=0 mid-DWAIT → all outputs 0, err_timeout=0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared state encoding and forward-select constants for pipe_hazard_ctrl
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LHOLD = 2'd1,
    DWAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_wdog.sv
// rtl/hazard_wdog.sv - data-memory wait watchdog: saturating DWAIT cycle counter with sticky timeout flag
module hazard_wdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait_i,
  output logic err_o
);

  localparam logic [7:0] MW = 8'(MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!in_wait_i) begin
      cnt_d = '0;
    end else if (cnt_q != MW) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (in_wait_i && (cnt_d == MW)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32 5-stage hazard/stall/forward controller; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              MemReqM,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              err_timeout,
  output logic [1:0]        load_cnt
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam logic [1:0] LS_INIT = 2'(LOAD_STALL - 1);

  state_e     state_q, state_d, ret_q, ret_d, eff_st;
  logic [1:0] cnt_q, cnt_d;
  logic       mstall, lu;
  logic       stall_f, stall_d, stall_emw, flush_d, flush_e;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      fwd_a = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) fwd_a = FWD_W;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      fwd_b = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) fwd_b = FWD_W;
  end

  // While in DWAIT the interrupted state is parked in ret_q; once memory
  // completes, control behaves as that state in the very same cycle.
  always_comb begin
    mstall    = MemReqM & ~dmem_ready;
    lu        = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    eff_st    = (state_q == DWAIT) ? ret_q : state_q;
    state_d   = RUN;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_emw = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (mstall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_emw = 1'b1;
      state_d   = DWAIT;
      if (state_q != DWAIT) ret_d = state_q;
    end else if (PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      cnt_d   = '0;
    end else if (eff_st == LHOLD) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      cnt_d   = cnt_q - 2'd1;
      state_d = (cnt_q == 2'd1) ? RUN : LHOLD;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = LHOLD;
        cnt_d   = LS_INIT;
      end
    end else if (!imem_ready) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  hazard_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk       (clk),
    .rst_n     (reset),
    .in_wait_i (state_q == DWAIT),
    .err_o     (err_timeout)
  );

  // Reset forces every control output quiet even with live inputs.
  assign ForwardAE = reset ? fwd_a : FWD_RF;
  assign ForwardBE = reset ? fwd_b : FWD_RF;
  assign StallF    = reset & stall_f;
  assign StallD    = reset & stall_d;
  assign StallE    = reset & stall_emw;
  assign StallM    = reset & stall_emw;
  assign StallW    = reset & stall_emw;
  assign FlushD    = reset & flush_d;
  assign FlushE    = reset & flush_e;
  assign load_cnt  = cnt_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (StallD) perf_stall_q <= perf_stall_q + 32'd1;
      if (FlushE) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (LOAD_STALL=2, MAX_WAIT=3)
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, MemReqM, dmem_ready, imem_ready, PCSrcE;
  logic [1:0] ForwardAE, ForwardBE, load_cnt;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, err_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(2), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .MemReqM(MemReqM),
    .dmem_ready(dmem_ready), .imem_ready(imem_ready), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .err_timeout(err_timeout), .load_cnt(load_cnt)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}
  logic [10:0] obs;
  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

  localparam logic [10:0] O_IDLE  = 11'b00_00_00000_00;
  localparam logic [10:0] O_LU    = 11'b00_00_11000_01;
  localparam logic [10:0] O_MEM   = 11'b00_00_11111_00;
  localparam logic [10:0] O_FETCH = 11'b00_00_10000_10;
  localparam logic [10:0] O_BR    = 11'b00_00_00000_11;

  typedef struct {
    logic [4:0]  rs1e, rs2e, rs1d, rs2d, rde, rdm, rdw;
    logic        rwm, rww, loade, memreq, dready, iready, pcsrc;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; MemReqM = 1'b0;
    dmem_ready = 1'b1; imem_ready = 1'b1; PCSrcE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_lu();
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  initial begin
    idle_in();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    MemReqM = 1'b1; dmem_ready = 1'b0;
    #2;
    check("reset_outputs", obs, O_IDLE);
    check("reset_err", err_timeout, 0);
    check("reset_load_cnt", load_cnt, 0);
    idle_in();
    @(negedge clk);
    reset = 1'b1;

    //          rs1e   rs2e   rs1d   rs2d   rde    rdm    rdw   rwm  rww  ld   mreq drdy irdy pcs  exp
    vecs[0] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, O_IDLE};
    vecs[1] = '{5'd5,  5'd0,  5'd0,  5'd0,  5'd0,  5'd5,  5'd5, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 11'b10_00_00000_00};
    vecs[2] = '{5'd5,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd5, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 11'b01_00_00000_00};
    vecs[3] = '{5'd0,  5'd3,  5'd0,  5'd0,  5'd0,  5'd3,  5'd3, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 11'b00_01_00000_00};
    vecs[4] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, O_IDLE};
    vecs[5] = '{5'd4,  5'd4,  5'd0,  5'd0,  5'd0,  5'd4,  5'd9, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 11'b10_10_00000_00};
    vecs[6] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_FETCH};
    vecs[7] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, O_BR};
    vecs[8] = '{5'd0,  5'd0,  5'd0,  5'd7,  5'd7,  5'd0,  5'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, O_BR};
    vecs[9] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, O_IDLE};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; LoadE = vecs[i].loade;
      MemReqM = vecs[i].memreq; dmem_ready = vecs[i].dready; imem_ready = vecs[i].iready;
      PCSrcE = vecs[i].pcsrc;
      #2;
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end
    check("after_branch_lu_load_cnt", load_cnt, 0);

    // Load-use with two bubbles
    do_reset();
    @(negedge clk); idle_in(); set_lu(); #2;
    check("lu_c1", obs, O_LU);
    check("lu_c1_cnt", load_cnt, 0);
    @(negedge clk); idle_in(); #2;
    check("lu_c2", obs, O_LU);
    check("lu_c2_cnt", load_cnt, 1);
    @(negedge clk); #2;
    check("lu_c3", obs, O_IDLE);
    check("lu_c3_cnt", load_cnt, 0);

    // Memory stall 4 cycles, then ready; watchdog (MAX_WAIT=3) trips
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); idle_in(); MemReqM = 1'b1; dmem_ready = 1'b0; #2;
      check($sformatf("mstall_c%0d", c), obs, O_MEM);
      check($sformatf("mstall_err_c%0d", c), err_timeout, 0);
    end
    @(negedge clk); dmem_ready = 1'b1; #2;
    check("mstall_ready", obs, O_IDLE);
    check("wdog_err_set", err_timeout, 1);
    @(negedge clk); idle_in(); #2;
    check("wdog_err_sticky", err_timeout, 1);
    check("post_mstall_idle", obs, O_IDLE);

    // LHOLD suspended by a memory stall, then resumed
    do_reset();
    @(negedge clk); idle_in(); set_lu(); #2;
    check("susp_lu", obs, O_LU);
    @(negedge clk); idle_in(); MemReqM = 1'b1; dmem_ready = 1'b0; #2;
    check("susp_mstall", obs, O_MEM);
    check("susp_cnt_frozen", load_cnt, 1);
    @(negedge clk); dmem_ready = 1'b1; #2;
    check("susp_resume", obs, O_LU);
    check("susp_resume_cnt", load_cnt, 1);
    @(negedge clk); idle_in(); #2;
    check("susp_done", obs, O_IDLE);
    check("susp_done_cnt", load_cnt, 0);

    // Branch during LHOLD cancels the remaining bubble
    do_reset();
    @(negedge clk); idle_in(); set_lu(); #2;
    check("br_lu", obs, O_LU);
    @(negedge clk); idle_in(); PCSrcE = 1'b1; #2;
    check("br_in_lhold", obs, O_BR);
    @(negedge clk); idle_in(); #2;
    check("br_after", obs, O_IDLE);
    check("br_after_cnt", load_cnt, 0);

    // Asynchronous reset in the middle of DWAIT
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle_in(); MemReqM = 1'b1; dmem_ready = 1'b0;
      Rs1E = 5'd6; RdM = 5'd6; RegWriteM = 1'b1;
    end
    #2;
    check("pre_areset_err", err_timeout, 1);
    check("pre_areset_obs", obs, 11'b10_00_11111_00);
    #1 reset = 1'b0;
    #1;
    check("areset_obs", obs, O_IDLE);
    check("areset_err", err_timeout, 0);
    check("areset_cnt", load_cnt, 0);
    @(negedge clk); idle_in(); reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
